clock_debounce: RTL and testbench
=================================

Name: clock_debounce

Overview:
- Combined clock-divider and input-debounce front end for slow mechanical inputs, such as rotary-encoder A/B lines and push buttons.
- Divides the system clock into a 50%-duty divided clock and a one-cycle sample tick.
- Debounces a WIDTH-bit input bus on that tick.
- Downstream logic uses the debounced levels and rising-edge pulses, all synchronous to clk; no derived clocks are needed.

Parameters:
- PAM, 49999: divider terminal count; divided period = PAM+1 clk cycles; must be >= 1.
- WIDTH, 2: number of independent input channels.
- DEPTH, 3: consecutive equal tick samples required to accept a new level; must be >= 2.
- INIT, 0: reset value of every debounced output bit and every history bit (1-bit, replicated).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- din  in  WIDTH  raw asynchronous inputs.
- clk_div  out  1  divided clock, registered, 50% duty (low half first).
- tick  out  1  one-clk strobe, once per divided period.
- dout  out  WIDTH  debounced levels, registered.
- rise  out  WIDTH  one-clk pulse per bit on a debounced 0->1 transition.

Behaviour:
Reset:
- When rst_n is low at a clk edge: cnt=0, clk_div=0, sync stages=INIT, histories=INIT, dout=INIT, rise=0.
- Reset takes priority over all other activity, including mid-operation.

Divider:
- cnt counts 0..PAM, then wraps to 0.
- tick = (cnt==PAM), decoded from the registered cnt; high exactly 1 of every PAM+1 cycles.
- HALF = (PAM+1)/2, integer division.
- clk_div is a register equal to (cnt >= HALF): cleared on the edge where cnt wraps to 0, set on the edge where cnt goes HALF-1 -> HALF.
- PAM odd: exact 50% duty. PAM even: high phase is one cycle longer.
- clk_div must never glitch.

Synchronizer:
- Each din bit passes through 2 flops every clk; s2 is the synchronized value.

Debounce, per bit, on each clk edge where tick=1:
- Shift s2 into a DEPTH-deep history register.
- If the new sample and the DEPTH-1 most recent prior samples are all equal and differ from dout, dout takes that value at this same edge.
- Non-tick cycles: history and dout hold.
- Any differing sample restarts the run.
- Channels are fully independent; simultaneous transitions on several bits are each handled normally.

rise:
- Registered, high for exactly one clk: the first cycle in which dout shows a new 1 after a 0.
- Never asserted on a 1->0 transition or by reset.

Latency:
- din change to dout update = 2 clk (sync) plus up to DEPTH ticks.
- The DEPTH ticks are counted from the first tick at or after s2 changes.

Test Plan:
- Reset: PAM=3, rst_n low 5 clk -> clk_div=0, tick=0, dout=00, rise=00; first tick exactly 4 clk after rst_n rises.
- Divider PAM=3: tick every 4th clk; clk_div sequence 0,0,1,1 repeating. PAM=4: clk_div low 2 cycles, high 3 cycles, tick period 5.
- Clean step, PAM=3, DEPTH=3: din[0] 0->1 held -> dout[0]=1 on the 3rd tick after s2 goes high; rise[0] one clk pulse; dout[1] and rise[1] unchanged.
- Glitch: din[0] high for only 2 tick periods, then low -> dout[0] stays 0, rise stays 0. Alternating samples 1,0,1,0 -> no change. Three consecutive 1 samples -> dout[0]=1.
- Falling edge and simultaneity: both bits 1 -> 0 together -> both dout bits clear on the same tick edge; rise remains 0.
- Reset mid-operation: with dout=11 and cnt=2, drive rst_n low for 1 clk -> next edge gives dout=00, cnt=0, clk_div=0, no rise pulse; normal operation resumes.

Source files
------------

// File: rtl/clock_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clock_debounce
//  Purpose  : Clock divider plus multi-channel input debouncer for slow
//             mechanical inputs (encoder lines, push buttons). The divider
//             makes a 50%-duty divided clock and a one-cycle sample tick.
//             Each input bit is synchronised and then debounced on that tick.
//             All outputs are synchronous to clk.
//  Ports    :
//     clk      in   1      system clock, rising edge
//     rst_n    in   1      synchronous active-low reset
//     din      in   WIDTH  raw asynchronous inputs
//     clk_div  out  1      registered divided clock, low half first
//     tick     out  1      one-clk strobe, once per PAM+1 cycles
//     dout     out  WIDTH  debounced levels
//     rise     out  WIDTH  one-clk pulse on a debounced 0->1 transition
//  Revision : 1.0  initial release
// ============================================================================
module clock_debounce #(
    parameter int   PAM   = 49999,  // divider terminal count (>= 1)
    parameter int   WIDTH = 2,      // number of input channels
    parameter int   DEPTH = 3,      // equal samples needed to accept (>= 2)
    parameter logic INIT  = 1'b0    // reset level of outputs and histories
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic             clk_div,
    output logic             tick,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise
);

    localparam int                 c_cnt_w = (PAM < 1) ? 1 : $clog2(PAM + 1);
    localparam logic [c_cnt_w-1:0] c_pam   = c_cnt_w'(PAM);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'((PAM + 1) / 2);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_clk_div;
    logic               w_tick;

    assign w_tick    = (r_cnt == c_pam);
    assign w_cnt_nxt = w_tick ? '0 : (r_cnt + c_one);

    // clk_div is computed from the next count so the register always
    // equals (cnt >= HALF) for the count it sits beside, and being a
    // plain flop output it cannot glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_div <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_div <= (w_cnt_nxt >= c_half);
        end
    end

    assign clk_div = r_clk_div;
    assign tick    = w_tick;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for every input bit
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= {WIDTH{INIT}};
            r_s2 <= {WIDTH{INIT}};
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_ch
            logic [DEPTH-1:0] r_hist;
            logic [DEPTH-1:0] w_hist_nxt;
            logic             w_stable;
            logic             w_accept;
            logic             r_dout;
            logic             r_rise;

            // The new sample joins the DEPTH-1 most recent ones; a level is
            // accepted as soon as that full window agrees, in the same edge.
            assign w_hist_nxt = {r_hist[DEPTH-2:0], r_s2[g]};
            assign w_stable   = (&w_hist_nxt) | ~(|w_hist_nxt);
            assign w_accept   = w_tick & w_stable & (w_hist_nxt[0] != r_dout);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_hist <= {DEPTH{INIT}};
                    r_dout <= INIT;
                    r_rise <= 1'b0;
                end else begin
                    if (w_tick) begin
                        r_hist <= w_hist_nxt;
                    end
                    if (w_accept) begin
                        r_dout <= w_hist_nxt[0];
                    end
                    // Registered alongside dout so the pulse lines up with
                    // the first cycle dout shows the new 1.
                    r_rise <= w_accept & w_hist_nxt[0];
                end
            end

            assign dout[g] = r_dout;
            assign rise[g] = r_rise;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clock_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_clock_debounce
//  Purpose  : Self-checking bench for clock_debounce. Two instances (PAM=3
//             and PAM=4) share one stimulus; a behavioural model predicts
//             every output each cycle, and literal expectations pin the
//             divider pattern, the step response and reset behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_debounce;

    localparam int W  = 2;
    localparam int D  = 3;
    localparam int P0 = 3;
    localparam int P1 = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din   = '0;

    logic         clk_div0, tick0, clk_div1, tick1;
    logic [W-1:0] dout0, rise0, dout1, rise1;

    always #5 clk = ~clk;

    clock_debounce #(.PAM(P0), .WIDTH(W), .DEPTH(D), .INIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .clk_div(clk_div0), .tick(tick0), .dout(dout0), .rise(rise0)
    );

    clock_debounce #(.PAM(P1), .WIDTH(W), .DEPTH(D), .INIT(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .clk_div(clk_div1), .tick(tick1), .dout(dout1), .rise(rise1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h",
                     nm, inst, $time, act, req);
        end
    endtask

    function automatic int pam_of(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: edge counting since reset, a two-deep delay queue
    // for the synchroniser, and per-bit run-length of equal tick samples.
    // ------------------------------------------------------------------
    bit           model_valid = 0;
    logic [W-1:0] dq[$];
    int           k[2];
    logic [W-1:0] m_dout[2];
    logic [W-1:0] m_rise[2];
    logic         run_val[2][W];
    int           run_len[2][W];
    logic [W-1:0] samp;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_valid = 1;
            dq.delete();
            dq.push_back('0);
            dq.push_back('0);
            for (int i = 0; i < 2; i++) begin
                k[i]      = 0;
                m_dout[i] = '0;
                m_rise[i] = '0;
                for (int b = 0; b < W; b++) begin
                    run_val[i][b] = 1'b0;
                    run_len[i][b] = D;
                end
            end
        end else if (model_valid) begin
            samp = dq[1];             // synchronised value seen at this edge
            dq.push_front(din);
            void'(dq.pop_back());
            for (int i = 0; i < 2; i++) begin
                m_rise[i] = '0;
                if ((k[i] % (pam_of(i) + 1)) == pam_of(i)) begin
                    for (int b = 0; b < W; b++) begin
                        if (samp[b] == run_val[i][b]) begin
                            if (run_len[i][b] < 1000) run_len[i][b]++;
                        end else begin
                            run_val[i][b] = samp[b];
                            run_len[i][b] = 1;
                        end
                        if (run_len[i][b] >= D && run_val[i][b] != m_dout[i][b]) begin
                            m_dout[i][b] = run_val[i][b];
                            m_rise[i][b] = run_val[i][b];
                        end
                    end
                end
                k[i]++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, away from the active edge
    // ------------------------------------------------------------------
    logic         a_cd[2];
    logic         a_tk[2];
    logic [W-1:0] a_do[2];
    logic [W-1:0] a_ri[2];
    assign a_cd[0] = clk_div0; assign a_cd[1] = clk_div1;
    assign a_tk[0] = tick0;    assign a_tk[1] = tick1;
    assign a_do[0] = dout0;    assign a_do[1] = dout1;
    assign a_ri[0] = rise0;    assign a_ri[1] = rise1;

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 2; i++) begin
                int cnt;
                cnt = k[i] % (pam_of(i) + 1);
                chk("model_clk_div", i, 32'(a_cd[i]), 32'(cnt >= (pam_of(i) + 1) / 2));
                chk("model_tick",    i, 32'(a_tk[i]), 32'(cnt == pam_of(i)));
                chk("model_dout",    i, 32'(a_do[i]), 32'(m_dout[i]));
                chk("model_rise",    i, 32'(a_ri[i]), 32'(m_rise[i]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [9:0] e_cd0, e_tk0, e_cd1, e_tk1;

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_cd0 = 10'b1001100110;
        e_tk0 = 10'b0001000100;
        e_cd1 = 10'b0111001110;
        e_tk1 = 10'b0100001000;

        // Reset held for 5 clocks
        rst_n = 1'b0;
        din   = '0;
        cyc(5);
        chk("rst_clk_div", 0, 32'(clk_div0), 32'(0));
        chk("rst_tick",    0, 32'(tick0),    32'(0));
        chk("rst_dout",    0, 32'(dout0),    32'(0));
        chk("rst_rise",    0, 32'(rise0),    32'(0));
        chk("rst_clk_div", 1, 32'(clk_div1), 32'(0));
        chk("rst_dout",    1, 32'(dout1),    32'(0));

        // Divider pattern for the first 10 edges after reset release
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cyc(1);
            chk("div_pattern_cd", 0, 32'(clk_div0), 32'(e_cd0[j]));
            chk("div_pattern_tk", 0, 32'(tick0),    32'(e_tk0[j]));
            chk("div_pattern_cd", 1, 32'(clk_div1), 32'(e_cd1[j]));
            chk("div_pattern_tk", 1, 32'(tick1),    32'(e_tk1[j]));
        end

        // Clean step on din[0]: accepted on the 3rd tick (12th edge)
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        din   = 2'b01;
        cyc(11);
        chk("step_before", 0, 32'(dout0), 32'(0));
        cyc(1);
        chk("step_dout", 0, 32'(dout0), 32'(1));
        chk("step_rise", 0, 32'(rise0), 32'(1));
        cyc(1);
        chk("step_rise_end", 0, 32'(rise0), 32'(0));
        chk("step_dout_hold", 0, 32'(dout0), 32'(1));

        // Glitch on din[1]: two tick periods high must not be accepted
        din = 2'b11;
        cyc(8);
        din = 2'b01;
        cyc(16);
        chk("glitch_dout", 0, 32'(dout0), 32'(1));

        // Alternating samples on din[1]
        for (int j = 0; j < 4; j++) begin
            din = (j % 2 == 0) ? 2'b11 : 2'b01;
            cyc(4);
        end
        din = 2'b01;
        cyc(16);
        chk("alt_dout", 0, 32'(dout0), 32'(1));

        // Both bits high, then both fall together
        din = 2'b11;
        cyc(16);
        chk("both_high", 0, 32'(dout0), 32'(3));
        din = 2'b00;
        cyc(16);
        chk("both_low", 0, 32'(dout0), 32'(0));

        // Reset mid-operation with dout=11 and cnt=2
        din = 2'b11;
        cyc(16);
        chk("pre_mid_rst", 0, 32'(dout0), 32'(3));
        for (int t = 0; t < 8 && (k[0] % (P0 + 1)) != 2; t++) cyc(1);
        if ((k[0] % (P0 + 1)) != 2) begin
            failures++;
            $display("FAIL align t=%0t actual=%0d required=2", $time, k[0] % (P0 + 1));
        end
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("mid_rst_dout",    0, 32'(dout0),    32'(0));
        chk("mid_rst_clk_div", 0, 32'(clk_div0), 32'(0));
        chk("mid_rst_tick",    0, 32'(tick0),    32'(0));
        chk("mid_rst_rise",    0, 32'(rise0),    32'(0));
        cyc(20);
        chk("resume_dout", 0, 32'(dout0), 32'(3));

        // Randomised stretch with occasional resets
        for (int n = 0; n < 300; n++) begin
            din = W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            cyc($urandom_range(1, 20));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
